// File: rtl/pal_job_scheduler.sv
// Round-robin arbiter and job sequencer sharing one pal_number_analyzer between NREQ requesters.
// Build macro PAL_SCHED_STATS_EN adds saturating job / palindrome / watchdog-error counters.
module pal_job_scheduler #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64,
    parameter int IDW     = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [32*NREQ-1:0]  req_data,
    output logic [NREQ-1:0]     grant,
    output logic [NREQ-1:0]     done,
    output logic                result_pal,
    output logic                result_err,
    output logic [IDW-1:0]      result_id,
    output logic                busy,
    output logic [31:0]         ana_number,
    output logic                ana_enable,
    input  logic                ana_ready,
    input  logic                ana_is_pal
`ifdef PAL_SCHED_STATS_EN
    ,
    output logic [15:0]         stat_jobs,
    output logic [15:0]         stat_pals,
    output logic [15:0]         stat_errs
`endif
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARB  = 3'd1,
        ST_LOAD = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4,
        ST_GAP  = 3'd5
    } state_t;

    state_t          state_r;
    logic [IDW-1:0]  rr_ptr_r;
    logic [IDW-1:0]  winner_r;
    logic [WDW-1:0]  wd_cnt_r;

    logic [IDW-1:0]  win_s;
    logic [IDW-1:0]  win_hi_s;
    logic [IDW-1:0]  win_lo_s;
    logic            found_hi_s;
    logic [IDW-1:0]  rr_next_s;
    logic [NREQ-1:0] win_onehot_s;

    // Round-robin pick: lowest set bit at or above rr_ptr, else lowest set bit overall (wrap).
    always_comb begin
        win_hi_s   = {IDW{1'b0}};
        win_lo_s   = {IDW{1'b0}};
        found_hi_s = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_lo_s = IDW'(i);
                if (i >= int'(rr_ptr_r)) begin
                    win_hi_s   = IDW'(i);
                    found_hi_s = 1'b1;
                end else begin
                    win_hi_s   = win_hi_s;
                end
            end else begin
                win_lo_s = win_lo_s;
            end
        end
        if (found_hi_s) begin
            win_s = win_hi_s;
        end else begin
            win_s = win_lo_s;
        end
    end

    // Pointer advance past the served requester and one-hot decode of the current pick.
    always_comb begin
        if (winner_r == IDW'(NREQ - 1)) begin
            rr_next_s = {IDW{1'b0}};
        end else begin
            rr_next_s = winner_r + IDW'(1);
        end
        win_onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
    end

    // Job sequencer; every output is registered and set on entry to the state that owns it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= {IDW{1'b0}};
            winner_r   <= {IDW{1'b0}};
            wd_cnt_r   <= {WDW{1'b0}};
            grant      <= {NREQ{1'b0}};
            done       <= {NREQ{1'b0}};
            result_pal <= 1'b0;
            result_err <= 1'b0;
            result_id  <= {IDW{1'b0}};
            busy       <= 1'b0;
            ana_number <= 32'd0;
            ana_enable <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|req) begin
                        state_r <= ST_ARB;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ARB: begin
                    if (|req) begin
                        grant      <= win_onehot_s;
                        winner_r   <= win_s;
                        ana_number <= req_data[32*win_s +: 32];
                        state_r    <= ST_LOAD;
                    end else begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // The analyzer captured ana_number while held disabled during this cycle.
                    ana_enable <= 1'b1;
                    wd_cnt_r   <= {WDW{1'b0}};
                    state_r    <= ST_RUN;
                end
                ST_RUN: begin
                    if (ana_ready) begin
                        result_pal <= ana_is_pal;
                        result_err <= 1'b0;
                        result_id  <= winner_r;
                        done       <= grant;
                        ana_enable <= 1'b0;
                        state_r    <= ST_DONE;
                    end else if (wd_cnt_r == WDW'(TIMEOUT - 1)) begin
                        result_pal <= 1'b0;
                        result_err <= 1'b1;
                        result_id  <= winner_r;
                        done       <= grant;
                        ana_enable <= 1'b0;
                        state_r    <= ST_DONE;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + WDW'(1);
                    end
                end
                ST_DONE: begin
                    done     <= {NREQ{1'b0}};
                    grant    <= {NREQ{1'b0}};
                    rr_ptr_r <= rr_next_s;
                    state_r  <= ST_GAP;
                end
                ST_GAP: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    grant      <= {NREQ{1'b0}};
                    done       <= {NREQ{1'b0}};
                    busy       <= 1'b0;
                    ana_enable <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef PAL_SCHED_STATS_EN
    // Saturating statistics, sampled once per job while in DONE (results are valid there).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_jobs <= 16'd0;
            stat_pals <= 16'd0;
            stat_errs <= 16'd0;
        end else if (state_r == ST_DONE) begin
            if (stat_jobs != 16'hFFFF) begin
                stat_jobs <= stat_jobs + 16'd1;
            end else begin
                stat_jobs <= stat_jobs;
            end
            if (result_pal && (stat_pals != 16'hFFFF)) begin
                stat_pals <= stat_pals + 16'd1;
            end else begin
                stat_pals <= stat_pals;
            end
            if (result_err && (stat_errs != 16'hFFFF)) begin
                stat_errs <= stat_errs + 16'd1;
            end else begin
                stat_errs <= stat_errs;
            end
        end else begin
            stat_jobs <= stat_jobs;
            stat_pals <= stat_pals;
            stat_errs <= stat_errs;
        end
    end
`endif

endmodule

// File: tb/tb_pal_job_scheduler.sv
// Directed, table-driven bench for pal_job_scheduler with a small behavioural analyzer model.
module tb_pal_job_scheduler;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;
    localparam int IDW     = 3;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   req = 4'b0000;
    logic [32*NREQ-1:0] req_data = 128'd0;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic              result_pal;
    logic              result_err;
    logic [IDW-1:0]    result_id;
    logic              busy;
    logic [31:0]       ana_number;
    logic              ana_enable;
    logic              ana_ready = 1'b0;
    logic              ana_is_pal = 1'b0;
`ifdef PAL_SCHED_STATS_EN
    logic [15:0]       stat_jobs;
    logic [15:0]       stat_pals;
    logic [15:0]       stat_errs;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int model_lat = 0;   // 0 = analyzer never reports ready
    int model_cnt = 0;

    pal_job_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .IDW(IDW)) dut (
        .clock(clock), .reset(reset), .req(req), .req_data(req_data),
        .grant(grant), .done(done), .result_pal(result_pal), .result_err(result_err),
        .result_id(result_id), .busy(busy), .ana_number(ana_number), .ana_enable(ana_enable),
        .ana_ready(ana_ready), .ana_is_pal(ana_is_pal)
`ifdef PAL_SCHED_STATS_EN
        , .stat_jobs(stat_jobs), .stat_pals(stat_pals), .stat_errs(stat_errs)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic is_dec_pal(input logic [31:0] x);
        longint unsigned n;
        longint unsigned r;
        n = {32'd0, x};
        r = 0;
        while (n != 0) begin
            r = r * 10 + n % 10;
            n = n / 10;
        end
        return (r == {32'd0, x});
    endfunction

    // Analyzer model: ready rises model_lat enabled cycles after enable, verdict is a decimal palindrome test.
    always @(negedge clock) begin
        if (reset || !ana_enable) begin
            model_cnt  = 0;
            ana_ready  = 1'b0;
            ana_is_pal = 1'b0;
        end else begin
            model_cnt  = model_cnt + 1;
            ana_ready  = (model_lat != 0) && (model_cnt >= model_lat);
            ana_is_pal = is_dec_pal(ana_number);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pal"}, 32'(result_pal), 32'd0);
        chk({tag, "_err"}, 32'(result_err), 32'd0);
        chk({tag, "_id"}, 32'(result_id), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_number"}, ana_number, 32'd0);
        chk({tag, "_enable"}, 32'(ana_enable), 32'd0);
    endtask

    // One full job: present request, follow it to DONE, then check GAP and IDLE.
    task automatic run_job(input string tag, input logic [3:0] rq, input logic [31:0] d, input int lat,
                           input bit drop, input logic [2:0] exp_id, input logic exp_pal,
                           input logic exp_err, input int exp_runs);
        int cyc;
        int runs;
        int load_cyc;
        bit got;
        bit overlap;
        bit unstable;
        logic [3:0] seen_g;
        logic [3:0] exp_g;
        logic [31:0] num0;
        exp_g = 4'b0001 << exp_id;
        model_lat = lat;
        req_data = {4{d}};
        req = rq;
        cyc = 0; runs = 0; load_cyc = 0; got = 1'b0; overlap = 1'b0; unstable = 1'b0;
        seen_g = 4'b0000; num0 = 32'd0;
        while (!got && cyc < 400) begin
            @(negedge clock);
            cyc++;
            if ($countones(grant) > 1) overlap = 1'b1;
            if (grant != 4'b0000 && seen_g == 4'b0000) begin
                seen_g = grant;
                num0 = ana_number;
            end
            if (grant != 4'b0000 && grant != seen_g) overlap = 1'b1;
            if (seen_g != 4'b0000 && ana_number != num0) unstable = 1'b1;
            if (ana_enable) runs++;
            else if (grant != 4'b0000 && runs == 0) load_cyc++;
            if (|done) got = 1'b1;
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'(exp_g));
        chk({tag, "_grant"}, 32'(grant), 32'(exp_g));
        chk({tag, "_id"}, 32'(result_id), 32'(exp_id));
        chk({tag, "_pal"}, 32'(result_pal), 32'(exp_pal));
        chk({tag, "_err"}, 32'(result_err), 32'(exp_err));
        chk({tag, "_en_in_done"}, 32'(ana_enable), 32'd0);
        chk({tag, "_run_cycles"}, 32'(runs), 32'(exp_runs));
        chk({tag, "_load_cycles"}, 32'(load_cyc), 32'd1);
        chk({tag, "_grant_onehot"}, 32'(overlap), 32'd0);
        chk({tag, "_number_stable"}, 32'(unstable), 32'd0);
        chk({tag, "_number"}, num0, d);
        if (drop) req = req & ~done;
        @(negedge clock);
        chk({tag, "_gap_grant"}, 32'(grant), 32'd0);
        chk({tag, "_gap_enable"}, 32'(ana_enable), 32'd0);
        chk({tag, "_gap_done"}, 32'(done), 32'd0);
        chk({tag, "_gap_busy"}, 32'(busy), 32'd1);
        chk({tag, "_gap_pal_held"}, 32'(result_pal), 32'(exp_pal));
        @(negedge clock);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [3:0]  rq;
        logic [31:0] data;
        int          lat;
        logic [2:0]  id;
        logic        pal;
        logic        err;
        int          runs;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int cyc;
        int runs;
        bit bad;
        vecs[0] = '{4'b0001, 32'd12321, 20, 3'd0, 1'b1, 1'b0, 20};  // single request
        vecs[1] = '{4'b0100, 32'd1234,   5, 3'd2, 1'b0, 1'b0,  5};  // non-palindrome
        vecs[2] = '{4'b0001, 32'd121,    3, 3'd0, 1'b1, 1'b0,  3};  // rr_ptr=3 wraps to 0
        vecs[3] = '{4'b0001, 32'd10,     3, 3'd0, 1'b0, 1'b0,  3};
        vecs[4] = '{4'b1000, 32'd777,    0, 3'd3, 1'b0, 1'b1, 64};  // watchdog
        vecs[5] = '{4'b0010, 32'd4554,   2, 3'd1, 1'b1, 1'b0,  2};  // normal after abort
        vecs[6] = '{4'b0010, 32'd9,     64, 3'd1, 1'b1, 1'b0, 64};  // ready ties timeout
        vecs[7] = '{4'b0001, 32'd11,    65, 3'd0, 1'b0, 1'b1, 64};  // ready one cycle late
        vecs[8] = '{4'b1001, 32'd5,      1, 3'd3, 1'b1, 1'b0,  1};  // rr_ptr=1 skips bit 0
        vecs[9] = '{4'b0001, 32'd5,      4, 3'd0, 1'b1, 1'b0,  4};  // leftover bit 0

        repeat (3) @(negedge clock);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clock);
        chk("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_job($sformatf("vec%0d", i), vecs[i].rq, vecs[i].data, vecs[i].lat, 1'b1,
                    vecs[i].id, vecs[i].pal, vecs[i].err, vecs[i].runs);
        end
        req = 4'b0000;

        // Round-robin with every request held from reset.
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int j = 0; j < 5; j++) begin
            run_job($sformatf("rr%0d", j), 4'b1111, 32'd121, 2, 1'b0, 3'(j % 4), 1'b1, 1'b0, 2);
        end
        req = 4'b0000;
        @(negedge clock);

        // Reset ten cycles into a job; rr_ptr is 1 beforehand, so bit 0 winning proves it was cleared.
        model_lat = 0;
        req_data = {4{32'd33}};
        req = 4'b0100;
        cyc = 0;
        runs = 0;
        while (runs < 10 && cyc < 100) begin
            @(negedge clock);
            cyc++;
            if (ana_enable) runs++;
        end
        chk("midrst_reached_run", 32'(runs), 32'd10);
        chk("midrst_grant_before", 32'(grant), 32'h4);
        #2;
        reset = 1'b1;
        req = 4'b0000;
        #1;
        chk_all_zero("midrst_async");
        repeat (2) @(negedge clock);
        reset = 1'b0;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (done != 4'b0000 || busy != 1'b0) bad = 1'b1;
        end
        chk("midrst_no_done", 32'(bad), 32'd0);
        run_job("post_rst", 4'b1001, 32'd5, 3, 1'b1, 3'd0, 1'b1, 1'b0, 3);
        req = 4'b0000;
        repeat (2) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pal_job_scheduler.md
Name: pal_job_scheduler

Overview:
- Round-robin arbiter and sequencer that shares one pal_number_analyzer between NREQ requesters.
- Per job: latches the winner's 32-bit number, drives the analyzer's number/enable, waits for the analyzer's ready flag (with a watchdog), then returns the verdict to the winner.
- Sits between the requester-side logic and a single analyzer instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 64, maximum cycles in RUN before a job is aborted.
- IDW, 3, width of result_id; must satisfy 2**IDW >= NREQ.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req  in  NREQ  per-requester request level; bit i is held until done[i].
- req_data  in  32*NREQ  requester i's number at bits [32*i+31:32*i]; stable while req[i]=1.
- grant  out  NREQ  one-hot; bit i is high from ARB exit until DONE exit while requester i is served.
- done  out  NREQ  one-cycle pulse to the served requester in the DONE state.
- result_pal  out  1  verdict, valid in the DONE cycle and held until the next DONE.
- result_err  out  1  1 = watchdog abort; valid and held like result_pal.
- result_id  out  IDW  index of the served requester; valid and held like result_pal.
- busy  out  1  high in every state except IDLE.
- ana_number  out  32  number driven to the analyzer.
- ana_enable  out  1  analyzer enable.
- ana_ready  in  1  analyzer out_ready.
- ana_is_pal  in  1  analyzer is_pal.

Behaviour:
- Reset (async): state=IDLE, rr_ptr=0. All outputs are 0: grant, done, result_pal, result_err, result_id, busy, ana_number, ana_enable.
- States: IDLE, ARB, LOAD, RUN, DONE, GAP.
- IDLE: if any req bit is set, go to ARB; otherwise stay.
- ARB (1 cycle):
  - Select the first set req bit scanning from rr_ptr upward, with wrap.
  - Set the one-hot grant bit and latch req_data[winner] into ana_number. Go to LOAD.
  - If req has dropped to 0 in this cycle, return to IDLE with no grant.
- LOAD (1 cycle): ana_enable=0 and ana_number is stable, so the analyzer sits in its reset state and captures the number. Go to RUN.
- RUN:
  - ana_enable=1; a watchdog counter starts at 0 and increments each cycle.
  - If ana_ready=1, capture result_pal=ana_is_pal and result_err=0, then go to DONE.
  - Otherwise, when the counter reaches TIMEOUT-1, set result_pal=0 and result_err=1, then go to DONE.
  - If ana_ready and the timeout occur in the same cycle, ana_ready wins.
- DONE (1 cycle):
  - done[winner]=1, result_id=winner, ana_enable=0, grant is still asserted.
  - rr_ptr = (winner+1) mod NREQ, wrapping at NREQ-1 back to 0. Go to GAP.
- GAP (1 cycle): grant=0, ana_enable=0. This guarantees the analyzer returns to its reset state and that the requester has seen done before re-arbitration. Go to IDLE.
- Latency: ready-to-done is 1 cycle after ana_ready is sampled. Back-to-back jobs cost at least 5 cycles of overhead: ARB, LOAD, DONE, GAP, IDLE.
- A requester dropping req mid-job does not abort the job; done still pulses.
- Reset mid-job: ana_enable drops immediately, no done is issued, and the job is lost.
- ana_number is zero-extended raw data with no sign handling; the analyzer interprets it.
- ana_ready seen outside RUN is ignored.

Optional Feature:
- Macro: PAL_SCHED_STATS_EN.
- When defined, the block adds three 16-bit outputs:
  - stat_jobs: number of DONE states.
  - stat_pals: number of DONE states with result_pal=1.
  - stat_errs: number of DONE states with result_err=1.
- All three counters are cleared by reset and saturate at 16'hFFFF.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Single request: req=4'b0001, data0=12321, analyzer model returns ready with is_pal=1 after 20 cycles. Required: grant=0001; done[0] one cycle after ready; result_pal=1, result_err=0, result_id=0; busy low after GAP.
- Non-palindrome: req[2] with data 1234 and a model reporting is_pal=0. Required: done[2] pulse, result_pal=0, result_id=2.
- Round-robin: all four req held high continuously from reset. Required: service order 0,1,2,3,0, with each grant one-hot and never overlapping.
- Watchdog: model never asserts ready, TIMEOUT=64. Required: exactly 64 RUN cycles, then done with result_err=1 and result_pal=0; the next job proceeds normally.
- Enable protocol: check that ana_enable is 0 in LOAD, DONE and GAP; that ana_number is stable through LOAD/RUN; and that two consecutive jobs (121 then 10) give result_pal=1 then 0.
- Reset mid-RUN: assert reset 10 cycles into a job. Required: all outputs 0 asynchronously, no done pulse, and the next request after release is served starting from rr_ptr=0.
